// File: rtl/determinante_nxn_seq.sv
// Sequential signed determinant engine for 2x2, 3x3 or 4x4 matrices with
// one shared multiplier, a start/busy/done handshake and an exact result.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             request, sampled only while idle
//   size              0=2x2, 1=3x3, 2=4x4, 3=reserved (err)
//   A                 row-major 4x4 matrix, element(0,0) in the MSBs
//   busy, done        operation in flight / one-cycle result strobe
//   det, det_full     truncated and exact signed determinant
//   overflow, err     det_full out of OUT_W range / reserved size
module determinante_nxn_seq #(
  parameter int W     = 8,
  parameter int OUT_W = 8,
  parameter int ACC_W = 4*W+6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [16*W-1:0]   A,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  det,
  output logic [ACC_W-1:0]  det_full,
  output logic              overflow,
  output logic              err
);

  if (ACC_W < 4*W+5) begin : g_acc_chk
    $error("ACC_W must be >= 4*W+5");
  end

  // a 2x2 minor of W-bit elements always fits in 2W+1 bits
  localparam int MW = 2*W+1;
  localparam int PW = 2*MW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] last;

  logic [16*W-1:0] a_q;
  logic [1:0]      sz_q;
  logic signed [MW-1:0]    tmp_q;
  logic signed [MW-1:0]    m_q [6];
  logic signed [MW-1:0]    n_q [6];
  logic signed [ACC_W-1:0] acc_q;
  logic                    done_q;
  logic [ACC_W-1:0]        det_full_q;
  logic                    ovf_q;
  logic                    err_q;

  logic [1:0] row, j, k;
  logic [2:0] pr, slot, fi;
  logic       bot, half, is_fin, neg;
  logic signed [MW-1:0]    op_a, op_b;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [MW-1:0]    minor;
  logic signed [ACC_W-1:0] res;
  logic [ACC_W-OUT_W:0]    hi;
  logic                    ovf_d;

  function automatic logic signed [MW-1:0] el(
    input logic [16*W-1:0] a,
    input logic [1:0]      i,
    input logic [1:0]      c
  );
    int b;
    logic signed [W-1:0] e;
    b = (15 - 4*int'(i) - int'(c)) * W;
    e = a[b +: W];
    return MW'(e);
  endfunction

  // column pair p: 0=01 1=02 2=03 3=12 4=13 5=23
  function automatic logic [1:0] pj(input logic [2:0] p);
    unique case (p)
      3'd0, 3'd1, 3'd2: return 2'd0;
      3'd3, 3'd4:       return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] pk(input logic [2:0] p);
    unique case (p)
      3'd0:       return 2'd1;
      3'd1, 3'd3: return 2'd2;
      default:    return 2'd3;
    endcase
  endfunction

  always_comb begin
    unique case (sz_q)
      2'd1:    last = 5'd8;
      2'd2:    last = 5'd29;
      default: last = 5'd1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (size == 2'd3) ? S_FIN : S_CALC;
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == last) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Step decode: minors take two cycles (first product, then subtract),
  // followed by the final products accumulated into acc_q.
  always_comb begin
    row    = 2'd0;
    pr     = 3'd0;
    slot   = 3'd0;
    bot    = 1'b0;
    half   = cnt_q[0];
    is_fin = 1'b0;
    fi     = 3'd0;
    unique case (sz_q)
      2'd0: begin
        row = 2'd0;
      end
      2'd1: begin
        if (cnt_q < 5'd6) begin
          row  = 2'd1;
          slot = 3'(cnt_q >> 1);
          pr   = (slot == 3'd2) ? 3'd3 : slot;
        end else begin
          is_fin = 1'b1;
          fi     = 3'(cnt_q - 5'd6);
        end
      end
      default: begin
        if (cnt_q < 5'd12) begin
          row  = 2'd0;
          pr   = 3'(cnt_q >> 1);
          slot = pr;
        end else if (cnt_q < 5'd24) begin
          row  = 2'd2;
          pr   = 3'((cnt_q - 5'd12) >> 1);
          slot = pr;
          bot  = 1'b1;
        end else begin
          is_fin = 1'b1;
          fi     = 3'(cnt_q - 5'd24);
        end
      end
    endcase
  end

  always_comb begin
    j    = pj(pr);
    k    = pk(pr);
    neg  = 1'b0;
    op_a = '0;
    op_b = '0;
    if (!is_fin) begin
      if (!half) begin
        op_a = el(a_q, row, j);
        op_b = el(a_q, row + 2'd1, k);
      end else begin
        op_a = el(a_q, row, k);
        op_b = el(a_q, row + 2'd1, j);
      end
    end else if (sz_q == 2'd1) begin
      // a00*M12 - a01*M02 + a02*M01
      op_a = m_q[3'd2 - fi];
      op_b = el(a_q, 2'd0, fi[1:0]);
      neg  = (fi == 3'd1);
    end else begin
      // top minor times complementary bottom minor
      op_a = m_q[fi];
      op_b = n_q[3'd5 - fi];
      neg  = (fi == 3'd1) || (fi == 3'd4);
    end
  end

  assign prod     = op_a * op_b;
  assign prod_ext = ACC_W'(prod);
  assign minor    = tmp_q - prod[MW-1:0];

  always_comb begin
    res = acc_q;
    if (sz_q == 2'd3) res = '0;
    else if (sz_q == 2'd0) res = ACC_W'(m_q[0]);
    hi    = res[ACC_W-1:OUT_W-1];
    ovf_d = !((&hi) || (~|hi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      sz_q       <= '0;
      tmp_q      <= '0;
      acc_q      <= '0;
      done_q     <= 1'b0;
      det_full_q <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        m_q[i] <= '0;
        n_q[i] <= '0;
      end
    end else begin
      if (state_q == S_IDLE && start) begin
        a_q   <= A;
        sz_q  <= size;
        acc_q <= '0;
      end
      if (state_q == S_CALC) begin
        if (is_fin) begin
          acc_q <= neg ? acc_q - prod_ext : acc_q + prod_ext;
        end else if (!half) begin
          tmp_q <= prod[MW-1:0];
        end else if (bot) begin
          n_q[slot] <= minor;
        end else begin
          m_q[slot] <= minor;
        end
      end
      done_q <= (state_q == S_FIN);
      if (state_q == S_FIN) begin
        det_full_q <= res;
        ovf_q      <= ovf_d;
        err_q      <= (sz_q == 2'd3);
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign det_full = det_full_q;
  assign det      = det_full_q[OUT_W-1:0];
  assign overflow = ovf_q;
  assign err      = err_q;

endmodule
